// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared opcode encodings, FSM state type and opcode decode
//                helpers for the HI/LO multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_core
//  Description : Iterative one-bit-per-cycle shift-add multiplier and
//                restoring divider on magnitudes, with sign fix-up applied
//                to the final (combinational) step so the result can be
//                committed on the same edge the counter reaches zero.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic               r_busy;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_operand;  // |multiplicand| or |divisor|
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = op_is_signed(op);
    assign w_neg_a  = w_signed & src_a[WIDTH-1];
    assign w_neg_b  = w_signed & src_b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -src_a : src_a;
    assign w_abs_b  = w_neg_b ? -src_b : src_b;

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    assign w_addend   = r_acc[0] ? r_operand : {WIDTH{1'b0}};
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and try a subtract.
    // The shifted remainder is below 2*divisor, so bit WIDTH of the difference is the borrow.
    assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_diff  = w_rem_shift - {1'b0, r_operand};
    assign w_qbit      = ~w_rem_diff[WIDTH];
    assign w_div_next  = {(w_qbit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_qbit};

    // Sign fix-up: product negated over 2*WIDTH, quotient/remainder over WIDTH.
    assign w_prod_fix = r_neg_res ? -w_mul_next : w_mul_next;
    assign w_quo      = w_div_next[WIDTH-1:0];
    assign w_rem      = w_div_next[2*WIDTH-1:WIDTH];

    assign result_lo = r_is_div ? (r_neg_res ? -w_quo : w_quo) : w_prod_fix[WIDTH-1:0];
    assign result_hi = r_is_div ? (r_neg_rem ? -w_rem : w_rem) : w_prod_fix[2*WIDTH-1:WIDTH];
    assign valid     = r_busy & (r_count == '0);

    // Operand latch on load, then one iteration per cycle until the counter expires or is cancelled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (load) begin
            r_busy    <= 1'b1;
            r_count   <= CW'(WIDTH - 1);
            r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
            r_operand <= w_abs_b;
            r_is_div  <= op_is_div(op);
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
        end else if (r_busy) begin
            if (cancel || (r_count == '0)) begin
                r_busy <= 1'b0;
            end else begin
                r_acc   <= r_is_div ? w_div_next : w_mul_next;
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : HI/LO special-register pair with an iterative MULT/MULTU/
//                DIV/DIVU engine, MTHI/MTLO writes and optional write-through
//                read bypass. Busy stalls the pipeline while an op runs.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata_hi,
    input  logic [WIDTH-1:0] wdata_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] rdata_hi,
    output logic [WIDTH-1:0] rdata_lo
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_zero_div;
    logic             w_load;
    logic             w_abort;
    logic             w_commit;
    logic             w_core_valid;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    // cancel beats a simultaneous start; divide by zero skips the iteration entirely.
    assign w_accept   = (r_state == IDLE) & start & ~cancel;
    assign w_zero_div = w_accept & op_is_div(op) & (src_b == '0);
    assign w_load     = w_accept & ~w_zero_div;
    // An MT write while running aborts the op just like a flush.
    assign w_abort    = (r_state == RUN) & (cancel | we_hi | we_lo);
    assign w_commit   = (r_state == RUN) & w_core_valid & ~w_abort;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .cancel    (w_abort),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .result_hi (w_core_hi),
        .result_lo (w_core_lo),
        .valid     (w_core_valid)
    );

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_zero_div) begin
                    w_state_next = DONE;
                end else if (w_load) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_core_valid) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register plus the divide-by-zero flag that accompanies the DONE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div_zero <= w_zero_div;
        end
    end

    // HI/LO update: result commit, otherwise independent MTHI/MTLO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else begin
            if (we_hi) begin
                r_hi <= wdata_hi;
            end
            if (we_lo) begin
                r_lo <= wdata_lo;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign div_zero = r_div_zero;

    generate
        if (BYPASS) begin : g_bypass
            assign rdata_hi = we_hi ? wdata_hi : r_hi;
            assign rdata_lo = we_lo ? wdata_lo : r_lo;
        end else begin : g_no_bypass
            assign rdata_hi = r_hi;
            assign rdata_lo = r_lo;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Self-checking bench for hilo_muldiv_unit (WIDTH=32,
//                BYPASS=1). Committed results are checked by a scoreboard
//                monitor; timing and control behaviour inline per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic [1:0]   op       = 2'b00;
    logic [W-1:0] src_a    = '0;
    logic [W-1:0] src_b    = '0;
    logic         cancel   = 1'b0;
    logic         we_hi    = 1'b0;
    logic         we_lo    = 1'b0;
    logic [W-1:0] wdata_hi = '0;
    logic [W-1:0] wdata_lo = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] rdata_hi;
    logic [W-1:0] rdata_lo;

    int checks = 0;
    int errors = 0;

    // Bench-side copy of the architectural HI/LO contents.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];

    // Signed/unsigned directed vectors with known results.
    logic [1:0]   t_op [5] = '{OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_MULT};
    logic [W-1:0] t_a  [5] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h80000000};
    logic [W-1:0] t_b  [5] = '{32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] t_hi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h40000000};
    logic [W-1:0] t_lo [5] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'h0};

    hilo_muldiv_unit #(
        .WIDTH  (W),
        .BYPASS (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata_hi (wdata_hi),
        .wdata_lo (wdata_lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .rdata_hi (rdata_hi),
        .rdata_lo (rdata_lo)
    );

    always #5 clk = ~clk;

    // Behavioural reference built from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa   = $signed(a);
        sb   = $signed(b);
        e.hi = hi;
        e.lo = lo;
        e.dz = 1'b0;
        case (o)
            OP_MULT: begin
                p    = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_DIV: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got done=1 hi=%h lo=%h required no done", rdata_hi, rdata_lo);
            end else begin
                e = sb_q.pop_front();
                if ({rdata_hi, rdata_lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
                    errors++;
                    $display("FAIL sb_result: got hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                             rdata_hi, rdata_lo, div_zero, e.hi, e.lo, e.dz);
                end
            end
        end
    end

    // Drive start for one cycle (cycle 0); returns 1ns into cycle 1.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input exp_t e);
        @(posedge clk); #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) begin
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done from cycle 1 on; cyc is the cycle index, or -1 if the budget expires.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i + 1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/dz=%b required 000", {busy, done, div_zero});
        end
        checks++;
        if ({rdata_hi, rdata_lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h required 0", {rdata_hi, rdata_lo});
        end
        rst = 1'b0;
    endtask

    task automatic test_multu_max();
        exp_t e;
        int   cyc;
        e.hi = 32'hFFFFFFFE;
        e.lo = 32'h00000001;
        e.dz = 1'b0;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, e);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL multu_busy_cycle1: got %b required 1", busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL multu_latency: got cycle %0d required 33", cyc);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL multu_after_done: got busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_signed_ops();
        exp_t e;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            e.hi = t_hi[i];
            e.lo = t_lo[i];
            e.dz = 1'b0;
            issue(t_op[i], t_a[i], t_b[i], 1'b1, e);
            wait_done(cyc);
            checks++;
            if (cyc != 33) begin
                errors++;
                $display("FAIL signed_latency[%0d]: got cycle %0d required 33", i, cyc);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   cyc;
        @(posedge clk); #1;
        we_hi    = 1'b1;
        we_lo    = 1'b1;
        wdata_hi = 32'hAA;
        wdata_lo = 32'hBB;
        @(posedge clk); #1;
        we_hi = 1'b0;
        we_lo = 1'b0;
        m_hi  = 32'hAA;
        m_lo  = 32'hBB;
        e.hi  = 32'hAA;
        e.lo  = 32'hBB;
        e.dz  = 1'b1;
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1, e);
        wait_done(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL divzero_latency: got cycle %0d required 1", cyc);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL divzero_cycle2: got busy/done/dz=%b required 000", {busy, done, div_zero});
        end
    endtask

    task automatic test_cancel();
        exp_t e;
        e = '0;
        issue(OP_MULT, 32'd3, 32'd5, 1'b0, e);
        // A start held through cycles 1-10 (a divide-by-zero would complete at once) must be ignored.
        start = 1'b1;
        op    = OP_DIVU;
        src_b = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) cancel = 1'b1;
            @(posedge clk); #1;
        end
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy_cycle11: got %b required 0", busy);
        end
        checks++;
        if ({rdata_hi, rdata_lo} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL cancel_hilo: got %h required %h", {rdata_hi, rdata_lo}, {m_hi, m_lo});
        end
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_stays_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_mt_bypass();
        @(posedge clk); #1;
        we_hi    = 1'b1;
        wdata_hi = 32'h12345678;
        #1;
        checks++;
        if (rdata_hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi_bypass: got %h required 12345678", rdata_hi);
        end
        @(posedge clk); #1;
        we_hi    = 1'b0;
        wdata_hi = '0;
        m_hi     = 32'h12345678;
        #1;
        checks++;
        if (rdata_hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi_register: got %h required 12345678", rdata_hi);
        end
    endtask

    task automatic test_mt_during_run();
        exp_t e;
        e = '0;
        issue(OP_MULTU, 32'd1234, 32'd5678, 1'b0, e);
        repeat (4) begin
            @(posedge clk); #1;
        end
        we_lo    = 1'b1;
        wdata_lo = 32'hCAFEF00D;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mtlo_run_busy: got %b required 1", busy);
        end
        @(posedge clk); #1;
        we_lo = 1'b0;
        m_lo  = 32'hCAFEF00D;
        #1;
        checks++;
        if ({busy, rdata_hi, rdata_lo} !== {1'b0, m_hi, m_lo}) begin
            errors++;
            $display("FAIL mtlo_run_abort: got busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
                     busy, rdata_hi, rdata_lo, m_hi, m_lo);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   cyc;
        e = '0;
        issue(OP_MULT, 32'd11, 32'd13, 1'b0, e);
        repeat (14) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL async_rst_busy: got busy/done=%b required 00", {busy, done});
        end
        checks++;
        if ({rdata_hi, rdata_lo} !== 64'd0) begin
            errors++;
            $display("FAIL async_rst_hilo: got %h required 0", {rdata_hi, rdata_lo});
        end
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        rst  = 1'b0;
        e.hi = 32'd0;
        e.lo = 32'd3;
        e.dz = 1'b0;
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1, e);
        wait_done(cyc);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL post_rst_divu_latency: got cycle %0d required 33", cyc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           cyc;
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (i == 3) o = OP_DIV;
            e = model(o, a, b, m_hi, m_lo);
            issue(o, a, b, 1'b1, e);
            wait_done(cyc);
            checks++;
            if (cyc != (e.dz ? 1 : 33)) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got cycle %0d required %0d", i, cyc, e.dz ? 1 : 33);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed_ops();
        test_div_zero();
        test_cancel();
        test_mt_bypass();
        test_mt_during_run();
        test_async_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
